// File: rtl/call_controller.sv
// call_controller
//   Per-phone call-control responder between the user interface and the
//   packet network. Accepts UI commands over a valid/ready handshake, runs
//   the call state machine, emits signalling packets through a one-entry
//   output slot and consumes signalling packets from remote phones.
//
// Parameters
//   ADDR_W          phone address width
//   TIMEOUT_CYCLES  ring/answer timeout in clocks (>= 2)
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready        UI command handshake
//   cmd, cmd_addr              0 NOP, 1 CALL, 2 ANSWER, 3 HANGUP, 4 REJECT; CALL target
//   net_in_valid/type/src      inbound packet strobe (always accepted)
//   net_out_valid/ready        outbound slot handshake
//   net_out_type/dst           outbound packet contents (REQ/ACK/NACK/END)
//   state                      0 IDLE, 1 INCOMING, 2 INITIATE, 3 BUSY, 4 CALL_WHILE_BUSY
//   peer_addr, second_addr     current partner, waiting caller
//   event_code                 one-cycle event pulse (the name `event` is a
//                              reserved word): 0 none, 1 connected,
//                              2 remote_end, 3 rejected, 4 timeout, 5 bad_cmd
module call_controller #(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 27_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              net_in_valid,
  input  logic [1:0]        net_in_type,
  input  logic [ADDR_W-1:0] net_in_src,
  output logic              net_out_valid,
  input  logic              net_out_ready,
  output logic [1:0]        net_out_type,
  output logic [ADDR_W-1:0] net_out_dst,
  output logic [2:0]        state,
  output logic [ADDR_W-1:0] peer_addr,
  output logic [ADDR_W-1:0] second_addr,
  output logic [2:0]        event_code
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INCOMING = 3'd1,
    ST_INITIATE = 3'd2,
    ST_BUSY     = 3'd3,
    ST_CWB      = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PKT_REQ  = 2'd0,
    PKT_ACK  = 2'd1,
    PKT_NACK = 2'd2,
    PKT_END  = 2'd3
  } pkt_t;

  typedef enum logic [2:0] {
    CMD_NOP    = 3'd0,
    CMD_CALL   = 3'd1,
    CMD_ANSWER = 3'd2,
    CMD_HANGUP = 3'd3,
    CMD_REJECT = 3'd4
  } cmd_t;

  typedef enum logic [2:0] {
    EV_NONE       = 3'd0,
    EV_CONNECTED  = 3'd1,
    EV_REMOTE_END = 3'd2,
    EV_REJECTED   = 3'd3,
    EV_TIMEOUT    = 3'd4,
    EV_BAD_CMD    = 3'd5
  } ev_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] peer_q, peer_d;
  logic [ADDR_W-1:0] second_q, second_d;
  ev_t               event_q, event_d;
  logic              swap_q, swap_d;
  logic              out_valid_q;
  pkt_t              out_type_q;
  logic [ADDR_W-1:0] out_dst_q;
  logic [TW-1:0]     timer_q;

  logic              timer_clr;
  logic              timer_sat;
  logic              timed;
  logic              handshake;
  logic              cmd_accept;
  logic              third_party;
  logic              load;
  pkt_t              load_type;
  logic [ADDR_W-1:0] load_dst;
  logic              listed;

  assign cmd_ready   = !out_valid_q && !net_in_valid && !swap_q;
  assign cmd_accept  = cmd_valid && cmd_ready;
  assign handshake   = out_valid_q && net_out_ready;
  assign timer_sat   = (timer_q == TW'(TIMEOUT_CYCLES - 1));
  assign timed       = (state_q == ST_INCOMING) || (state_q == ST_INITIATE) ||
                       (state_q == ST_CWB);
  assign third_party = (net_in_src != peer_q) &&
                       !((state_q == ST_CWB) && (net_in_src == second_q));

  assign state         = state_q;
  assign peer_addr     = peer_q;
  assign second_addr   = second_q;
  assign event_code    = event_q;
  assign net_out_valid = out_valid_q;
  assign net_out_type  = out_type_q;
  assign net_out_dst   = out_dst_q;

  // Priority: pending swap, then inbound packet, then command, then timeout.
  // A command and an inbound packet are mutually exclusive through cmd_ready;
  // a command accepted on the saturated-timer cycle defers the timeout by one.
  always_comb begin
    state_d   = state_q;
    peer_d    = peer_q;
    second_d  = second_q;
    event_d   = EV_NONE;
    swap_d    = swap_q;
    timer_clr = 1'b0;
    load      = 1'b0;
    load_type = PKT_REQ;
    load_dst  = peer_q;
    listed    = 1'b0;

    if (swap_q) begin
      // The END to the old peer leaves this cycle; the ACK to the waiting
      // caller refills the slot in the same cycle.
      if (handshake) begin
        load      = 1'b1;
        load_type = PKT_ACK;
        load_dst  = second_q;
        peer_d    = second_q;
        state_d   = ST_BUSY;
        swap_d    = 1'b0;
        event_d   = EV_CONNECTED;
      end
    end else if (net_in_valid) begin
      if (state_q == ST_IDLE) begin
        if (net_in_type == PKT_REQ) begin
          peer_d    = net_in_src;
          state_d   = ST_INCOMING;
          timer_clr = 1'b1;
        end
      end else if (third_party) begin
        if (net_in_type == PKT_REQ) begin
          if (state_q == ST_BUSY) begin
            second_d  = net_in_src;
            state_d   = ST_CWB;
            timer_clr = 1'b1;
          end else if (!out_valid_q) begin
            load      = 1'b1;
            load_type = PKT_NACK;
            load_dst  = net_in_src;
          end
        end
      end else begin
        unique case (state_q)
          ST_INITIATE: begin
            case (net_in_type)
              PKT_ACK: begin
                state_d = ST_BUSY;
                event_d = EV_CONNECTED;
              end
              PKT_NACK: begin
                state_d = ST_IDLE;
                event_d = EV_REJECTED;
              end
              PKT_END: begin
                state_d = ST_IDLE;
                event_d = EV_REMOTE_END;
              end
              default: ;
            endcase
          end
          ST_INCOMING, ST_BUSY: begin
            if (net_in_type == PKT_END) begin
              state_d = ST_IDLE;
              event_d = EV_REMOTE_END;
            end
          end
          ST_CWB: begin
            if (net_in_type == PKT_END) begin
              if (net_in_src == peer_q) begin
                peer_d    = second_q;
                state_d   = ST_INCOMING;
                event_d   = EV_REMOTE_END;
                timer_clr = 1'b1;
              end else begin
                state_d = ST_BUSY;
              end
            end
          end
          default: ;
        endcase
      end
    end else if (cmd_accept) begin
      unique case (state_q)
        ST_IDLE: begin
          if (cmd == CMD_CALL) begin
            listed    = 1'b1;
            load      = 1'b1;
            load_type = PKT_REQ;
            load_dst  = cmd_addr;
            peer_d    = cmd_addr;
            state_d   = ST_INITIATE;
            timer_clr = 1'b1;
          end
        end
        ST_INITIATE: begin
          if (cmd == CMD_HANGUP) begin
            listed    = 1'b1;
            load      = 1'b1;
            load_type = PKT_END;
            state_d   = ST_IDLE;
          end
        end
        ST_INCOMING: begin
          if (cmd == CMD_ANSWER) begin
            listed    = 1'b1;
            load      = 1'b1;
            load_type = PKT_ACK;
            state_d   = ST_BUSY;
            event_d   = EV_CONNECTED;
          end else if (cmd == CMD_REJECT || cmd == CMD_HANGUP) begin
            listed    = 1'b1;
            load      = 1'b1;
            load_type = PKT_NACK;
            state_d   = ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (cmd == CMD_HANGUP) begin
            listed    = 1'b1;
            load      = 1'b1;
            load_type = PKT_END;
            state_d   = ST_IDLE;
          end
        end
        ST_CWB: begin
          if (cmd == CMD_REJECT) begin
            listed    = 1'b1;
            load      = 1'b1;
            load_type = PKT_NACK;
            load_dst  = second_q;
            state_d   = ST_BUSY;
          end else if (cmd == CMD_HANGUP) begin
            listed    = 1'b1;
            load      = 1'b1;
            load_type = PKT_END;
            peer_d    = second_q;
            state_d   = ST_INCOMING;
            timer_clr = 1'b1;
          end else if (cmd == CMD_ANSWER) begin
            listed    = 1'b1;
            load      = 1'b1;
            load_type = PKT_END;
            swap_d    = 1'b1;
          end
        end
        default: ;
      endcase
      if (!listed && cmd != CMD_NOP) begin
        event_d = EV_BAD_CMD;
      end
    end else if (timed && timer_sat && !out_valid_q) begin
      load    = 1'b1;
      event_d = EV_TIMEOUT;
      unique case (state_q)
        ST_INITIATE: begin
          load_type = PKT_END;
          state_d   = ST_IDLE;
        end
        ST_INCOMING: begin
          load_type = PKT_NACK;
          state_d   = ST_IDLE;
        end
        ST_CWB: begin
          load_type = PKT_NACK;
          load_dst  = second_q;
          state_d   = ST_BUSY;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      peer_q      <= '0;
      second_q    <= '0;
      event_q     <= EV_NONE;
      swap_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_type_q  <= PKT_REQ;
      out_dst_q   <= '0;
      timer_q     <= '0;
    end else begin
      state_q  <= state_d;
      peer_q   <= peer_d;
      second_q <= second_d;
      event_q  <= event_d;
      swap_q   <= swap_d;
      if (load) begin
        out_valid_q <= 1'b1;
        out_type_q  <= load_type;
        out_dst_q   <= load_dst;
      end else if (handshake) begin
        out_valid_q <= 1'b0;
      end
      if (timer_clr) begin
        timer_q <= '0;
      end else if (!timer_sat) begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_call_controller.sv
// tb_call_controller
//   Directed test-plan scenarios followed by a randomized phase, all checked
//   against a behavioural call model. The model tracks the ring timer as the
//   number of clocks elapsed since entering a timed state.
module tb_call_controller;

  localparam int T = 16;

  localparam logic [1:0] REQ  = 2'd0;
  localparam logic [1:0] ACK  = 2'd1;
  localparam logic [1:0] NACK = 2'd2;
  localparam logic [1:0] ENDP = 2'd3;

  localparam logic [2:0] NOP    = 3'd0;
  localparam logic [2:0] CALL   = 3'd1;
  localparam logic [2:0] ANSWER = 3'd2;
  localparam logic [2:0] HANGUP = 3'd3;
  localparam logic [2:0] REJECT = 3'd4;

  localparam int IDLE = 0, INC = 1, INIT = 2, BUSY = 3, CWB = 4;

  logic       clk = 1'b1;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd;
  logic [7:0] cmd_addr;
  logic       net_in_valid;
  logic [1:0] net_in_type;
  logic [7:0] net_in_src;
  logic       net_out_valid;
  logic       net_out_ready;
  logic [1:0] net_out_type;
  logic [7:0] net_out_dst;
  logic [2:0] state;
  logic [7:0] peer_addr;
  logic [7:0] second_addr;
  logic [2:0] event_code;

  call_controller #(.ADDR_W(8), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd), .cmd_addr(cmd_addr),
    .net_in_valid(net_in_valid), .net_in_type(net_in_type), .net_in_src(net_in_src),
    .net_out_valid(net_out_valid), .net_out_ready(net_out_ready),
    .net_out_type(net_out_type), .net_out_dst(net_out_dst),
    .state(state), .peer_addr(peer_addr), .second_addr(second_addr),
    .event_code(event_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model
  int         m_state;
  logic [7:0] m_peer, m_second;
  int         m_event;
  logic       m_ov, m_swap;
  logic [1:0] m_otype;
  logic [7:0] m_odst;
  int         ncyc = 0;
  int         m_entry = 0;
  logic       ready_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = IDLE; m_peer = '0; m_second = '0; m_event = 0;
    m_ov = 1'b0; m_swap = 1'b0; m_otype = '0; m_odst = '0;
  endtask

  task automatic model_step(input logic rst, input logic cv, input logic [2:0] c,
                            input logic [7:0] ca, input logic iv, input logic [1:0] it,
                            input logic [7:0] isrc, input logic ordy);
    int ns = m_state;
    logic [7:0] np = m_peer, nsec = m_second;
    int ev = 0;
    logic sw = m_swap, snd = 1'b0, restart = 1'b0;
    logic [1:0] st = 2'd0;
    logic [7:0] sd = 8'd0;
    logic rdy = !m_ov && !iv && !m_swap;
    logic from_peer = (isrc == m_peer);
    logic from_second = (m_state == CWB) && (isrc == m_second);
    logic expired = (m_state == INC || m_state == INIT || m_state == CWB) &&
                    ((ncyc - m_entry) >= T - 1);
    logic ok;
    ncyc++;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_swap) begin
      if (m_ov && ordy) begin
        snd = 1; st = ACK; sd = m_second; np = m_second; ns = BUSY; sw = 0; ev = 1;
      end
    end else if (iv) begin
      if (m_state == IDLE) begin
        if (it == REQ) begin np = isrc; ns = INC; restart = 1; end
      end else if (!from_peer && !from_second) begin
        if (it == REQ) begin
          if (m_state == BUSY) begin nsec = isrc; ns = CWB; restart = 1; end
          else if (!m_ov) begin snd = 1; st = NACK; sd = isrc; end
        end
      end else if (m_state == INIT) begin
        if (it == ACK) begin ns = BUSY; ev = 1; end
        else if (it == NACK) begin ns = IDLE; ev = 3; end
        else if (it == ENDP) begin ns = IDLE; ev = 2; end
      end else if (m_state == INC || m_state == BUSY) begin
        if (it == ENDP) begin ns = IDLE; ev = 2; end
      end else if (m_state == CWB && it == ENDP) begin
        if (from_peer) begin np = m_second; ns = INC; ev = 2; restart = 1; end
        else ns = BUSY;
      end
    end else if (cv && rdy) begin
      ok = 1;
      if (m_state == IDLE && c == CALL) begin
        snd = 1; st = REQ; sd = ca; np = ca; ns = INIT; restart = 1;
      end else if ((m_state == INIT || m_state == BUSY) && c == HANGUP) begin
        snd = 1; st = ENDP; sd = m_peer; ns = IDLE;
      end else if (m_state == INC && c == ANSWER) begin
        snd = 1; st = ACK; sd = m_peer; ns = BUSY; ev = 1;
      end else if (m_state == INC && (c == REJECT || c == HANGUP)) begin
        snd = 1; st = NACK; sd = m_peer; ns = IDLE;
      end else if (m_state == CWB && c == REJECT) begin
        snd = 1; st = NACK; sd = m_second; ns = BUSY;
      end else if (m_state == CWB && c == HANGUP) begin
        snd = 1; st = ENDP; sd = m_peer; np = m_second; ns = INC; restart = 1;
      end else if (m_state == CWB && c == ANSWER) begin
        snd = 1; st = ENDP; sd = m_peer; sw = 1;
      end else ok = 0;
      if (!ok && c != NOP) ev = 5;
    end else if (expired && !m_ov) begin
      snd = 1; ev = 4;
      if (m_state == INIT) begin st = ENDP; sd = m_peer; ns = IDLE; end
      else if (m_state == INC) begin st = NACK; sd = m_peer; ns = IDLE; end
      else begin st = NACK; sd = m_second; ns = BUSY; end
    end
    if (restart) m_entry = ncyc;
    if (snd) begin m_ov = 1; m_otype = st; m_odst = sd; end
    else if (m_ov && ordy) m_ov = 0;
    m_state = ns; m_peer = np; m_second = nsec; m_event = ev; m_swap = sw;
  endtask

  task automatic compare_all();
    check("state", state, m_state);
    check("peer_addr", peer_addr, m_peer);
    check("second_addr", second_addr, m_second);
    check("event", event_code, m_event);
    check("net_out_valid", net_out_valid, m_ov);
    check("net_out_type", net_out_type, m_otype);
    check("net_out_dst", net_out_dst, m_odst);
  endtask

  task automatic step(input logic rst, input logic cv, input logic [2:0] c,
                      input logic [7:0] ca, input logic iv, input logic [1:0] it,
                      input logic [7:0] isrc, input logic ordy);
    reset = rst; cmd_valid = cv; cmd = c; cmd_addr = ca;
    net_in_valid = iv; net_in_type = it; net_in_src = isrc; net_out_ready = ordy;
    @(negedge clk);
    ready_seen = cmd_ready;
    check("cmd_ready", cmd_ready, {31'b0, !m_ov && !iv && !m_swap});
    model_step(rst, cv, c, ca, iv, it, isrc, ordy);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_step(input logic ordy);
    step(1'b0, 1'b0, NOP, 8'h00, 1'b0, REQ, 8'h00, ordy);
  endtask

  task automatic cmd_step(input logic [2:0] c, input logic [7:0] ca, input logic ordy);
    step(1'b0, 1'b1, c, ca, 1'b0, REQ, 8'h00, ordy);
  endtask

  task automatic pkt_step(input logic [1:0] t, input logic [7:0] src, input logic ordy);
    step(1'b0, 1'b0, NOP, 8'h00, 1'b1, t, src, ordy);
  endtask

  function automatic logic [7:0] pick_addr();
    case ($urandom_range(0, 5))
      0, 1: return m_peer;
      2: return m_second;
      default: return 8'h30 + 8'($urandom_range(0, 3));
    endcase
  endfunction

  initial begin
    logic       r_rst, r_cv, r_iv, r_ordy;
    logic [2:0] r_c;
    logic [1:0] r_t;
    int unsigned r;

    reset = 1'b1; cmd_valid = 1'b0; cmd = '0; cmd_addr = '0;
    net_in_valid = 1'b0; net_in_type = '0; net_in_src = '0; net_out_ready = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check("reset_state", state, 0);
    check("reset_out_valid", net_out_valid, 0);
    check("reset_event", event_code, 0);
    check("reset_peer", peer_addr, 0);
    check("reset_cmd_ready", cmd_ready, 1);

    // Outgoing call
    cmd_step(CALL, 8'h2A, 1'b0);
    check("call_state", state, 2);
    check("call_type", net_out_type, REQ);
    check("call_dst", net_out_dst, 8'h2A);
    idle_step(1'b1);
    check("call_drained", net_out_valid, 0);
    pkt_step(ACK, 8'h2A, 1'b1);
    check("ack_state", state, 3);
    check("ack_event", event_code, 1);
    idle_step(1'b1);
    check("event_one_cycle", event_code, 0);
    cmd_step(HANGUP, 8'h00, 1'b0);
    check("hangup_type", net_out_type, ENDP);
    check("hangup_dst", net_out_dst, 8'h2A);
    check("hangup_state", state, 0);
    idle_step(1'b1);

    // Incoming call that times out
    pkt_step(REQ, 8'h05, 1'b1);
    check("ring_state", state, 1);
    check("ring_peer", peer_addr, 8'h05);
    for (int i = 1; i < T; i++) begin
      idle_step(1'b1);
      check("ring_wait", {state, net_out_valid}, {3'd1, 1'b0});
    end
    idle_step(1'b1);
    check("timeout_state", state, 0);
    check("timeout_event", event_code, 4);
    check("timeout_type", net_out_type, NACK);
    check("timeout_dst", net_out_dst, 8'h05);
    idle_step(1'b1);

    // Call waiting with swap under backpressure
    pkt_step(REQ, 8'h05, 1'b1);
    cmd_step(ANSWER, 8'h00, 1'b0);
    check("answer_event", event_code, 1);
    idle_step(1'b1);
    pkt_step(REQ, 8'h09, 1'b1);
    check("cwb_state", state, 4);
    check("cwb_second", second_addr, 8'h09);
    cmd_step(ANSWER, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      idle_step(1'b0);
      check("swap_hold", {net_out_valid, net_out_type, net_out_dst, cmd_ready},
            {1'b1, ENDP, 8'h05, 1'b0});
    end
    idle_step(1'b1);
    check("swap_type", net_out_type, ACK);
    check("swap_dst", net_out_dst, 8'h09);
    check("swap_peer", peer_addr, 8'h09);
    check("swap_state", state, 3);
    idle_step(1'b1);
    cmd_step(HANGUP, 8'h00, 1'b1);
    idle_step(1'b1);

    // Command colliding with an inbound REQ
    step(1'b0, 1'b1, CALL, 8'h40, 1'b1, REQ, 8'h11, 1'b1);
    check("collide_ready", ready_seen, 0);
    check("collide_state", state, 1);
    check("collide_peer", peer_addr, 8'h11);
    cmd_step(CALL, 8'h40, 1'b1);
    check("late_call_event", event_code, 5);
    cmd_step(REJECT, 8'h00, 1'b1);
    idle_step(1'b1);

    // Third caller while ringing, then an illegal command
    pkt_step(REQ, 8'h05, 1'b1);
    pkt_step(REQ, 8'h33, 1'b1);
    check("third_nack", {net_out_valid, net_out_type, net_out_dst}, {1'b1, NACK, 8'h33});
    check("third_state", state, 1);
    idle_step(1'b1);
    cmd_step(3'd6, 8'h00, 1'b1);
    check("illegal_event", event_code, 5);
    check("illegal_state", state, 1);
    cmd_step(HANGUP, 8'h00, 1'b1);
    idle_step(1'b1);

    // Reset in the middle of a pending packet
    cmd_step(CALL, 8'h2A, 1'b0);
    check("pre_reset_valid", net_out_valid, 1);
    step(1'b1, 1'b0, NOP, 8'h00, 1'b0, REQ, 8'h00, 1'b0);
    check("mid_reset_valid", net_out_valid, 0);
    check("mid_reset_state", state, 0);
    check("mid_reset_ready", cmd_ready, 1);

    // Randomized phase
    for (int n = 0; n < 4000; n++) begin
      r_rst  = ($urandom_range(0, 299) == 0);
      r_cv   = ($urandom_range(0, 1) == 1);
      r_iv   = ($urandom_range(0, 4) == 0);
      r_ordy = ($urandom_range(0, 9) < 6);
      r_t    = 2'($urandom_range(0, 3));
      r      = $urandom_range(0, 19);
      if (r == 0) r_c = NOP;
      else if (r == 1) r_c = 3'($urandom_range(5, 7));
      else r_c = 3'(1 + r % 4);
      step(r_rst, r_cv, r_c, pick_addr(), r_iv, r_t, pick_addr(), r_ordy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
